// File: rtl/match_phase_ctrl.sv
// -----------------------------------------------------------------------------
// match_phase_ctrl
//
// Sequencer for the phase-match compare tree. Takes one search request
// (target phase, first RAM word, word count), reads LANES reference phases per
// cycle from the reference RAM, forms wrapped errors (ref - target) together
// with absolute candidate positions, feeds the compare tree and folds the
// per-word tree winners into one running best. The final {error, position}
// leaves on a valid/ready result port.
//
// Optional feature macro: MATCH_THRESH_EN
//   defined   : adds port thresh_i. Once a fold brings |best| <= thresh_i the
//               controller stops issuing reads, drains what is in flight and
//               reports the best of the words actually read.
//   undefined : every requested word is searched.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_vld/req_rdy                  request handshake
//   req_target/req_base/req_words    target phase, first word, word count (0 ok)
//   rd_en/rd_addr/rd_data            reference RAM read port (RD_LAT latency)
//   tree_err_o/tree_pos_o/tree_vld_o per-lane candidates to the compare tree
//   tree_err_i/tree_pos_i/tree_vld_i tree winner (TREE_LAT after tree_vld_o)
//   res_vld/res_rdy/res_err/res_pos  result handshake, signed error, position
//   thresh_i                         early-stop threshold (MATCH_THRESH_EN only)
// -----------------------------------------------------------------------------
module match_phase_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 2,
  parameter int TREE_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [DATA_WIDTH-1:0]       req_target,
  input  logic [ADDR_WIDTH-1:0]       req_base,
  input  logic [ADDR_WIDTH:0]         req_words,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic [LANES*DATA_WIDTH-1:0] tree_err_o,
  output logic [LANES*DATA_WIDTH-1:0] tree_pos_o,
  output logic                        tree_vld_o,
  input  logic [DATA_WIDTH-1:0]       tree_err_i,
  input  logic [DATA_WIDTH-1:0]       tree_pos_i,
  input  logic                        tree_vld_i,
  output logic                        res_vld,
  input  logic                        res_rdy,
  output logic [DATA_WIDTH-1:0]       res_err,
  output logic [DATA_WIDTH-1:0]       res_pos
`ifdef MATCH_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0]       thresh_i
`endif
);

  // The flush must outlast everything that can still be in the RAM and tree
  // pipelines when a search is abandoned.
  localparam int FLUSH_CYCLES = RD_LAT + TREE_LAT + 1;
  localparam int FC_W         = $clog2(FLUSH_CYCLES + 1);

  localparam logic [FC_W-1:0]       FC_ONE     = {{(FC_W-1){1'b0}}, 1'b1};
  localparam logic [FC_W-1:0]       FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DW_ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DW_ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ERR_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] ERR_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] POS_NONE   = {DATA_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Magnitude of a two's-complement error; the most negative value has no
  // positive counterpart and is clamped to the largest positive one.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] e);
    logic [DATA_WIDTH-1:0] r;
    if (e == ERR_MIN) begin
      r = ERR_MAX;
    end else if (e[DATA_WIDTH-1]) begin
      r = (~e) + DW_ONE;
    end else begin
      r = e;
    end
    return r;
  endfunction

  // Absolute candidate position: word offset * LANES + lane, wrapped to DW bits.
  function automatic logic [DATA_WIDTH-1:0] lane_pos(input logic [ADDR_WIDTH:0] k, input int j);
    return DATA_WIDTH'(k) * DATA_WIDTH'(LANES) + DATA_WIDTH'(j);
  endfunction

  state_t                 state;
  state_t                 state_nxt;
  logic [FC_W-1:0]        flush_cnt;
  logic [DATA_WIDTH-1:0]  target;
  logic [ADDR_WIDTH:0]    words;
  logic [ADDR_WIDTH:0]    issue_cnt;
  logic [ADDR_WIDTH:0]    ret_cnt;
  logic [ADDR_WIDTH:0]    ret_cnt_nxt;
  logic [DATA_WIDTH-1:0]  best_err;
  logic [DATA_WIDTH-1:0]  best_pos;
  logic [DATA_WIDTH-1:0]  best_err_nxt;
  logic [DATA_WIDTH-1:0]  best_pos_nxt;
  logic                   accept;
  logic                   fold_en;
  logic                   thresh_hit;
  logic [RD_LAT-1:0]      v_pipe;
  logic [ADDR_WIDTH:0]    off_pipe [RD_LAT];
`ifdef MATCH_THRESH_EN
  logic [DATA_WIDTH-1:0]  thresh;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, winner fold and request accept.
  always_comb begin
    state_nxt    = state;
    best_err_nxt = best_err;
    best_pos_nxt = best_pos;
    ret_cnt_nxt  = ret_cnt;
    accept       = 1'b0;
    thresh_hit   = 1'b0;
    // Winners only count while a search is live; anything the tree returns
    // during FLUSH or IDLE is stale.
    fold_en = tree_vld_i && ((state == ISSUE) || (state == DRAIN));

    // Strict less-than: words come back in issue order, so earlier words keep ties.
    if (fold_en) begin
      ret_cnt_nxt = ret_cnt + CNT_ONE;
      if (abs_sat(tree_err_i) < abs_sat(best_err)) begin
        best_err_nxt = tree_err_i;
        best_pos_nxt = tree_pos_i;
      end else begin
        best_err_nxt = best_err;
        best_pos_nxt = best_pos;
      end
    end else begin
      ret_cnt_nxt = ret_cnt;
    end

`ifdef MATCH_THRESH_EN
    if (fold_en && (abs_sat(best_err_nxt) <= thresh)) begin
      thresh_hit = 1'b1;
    end else begin
      thresh_hit = 1'b0;
    end
`else
    thresh_hit = 1'b0;
`endif

    case (state)
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FLUSH;
        end
      end
      IDLE: begin
        if (req_vld) begin
          accept       = 1'b1;
          best_err_nxt = ERR_MAX;
          best_pos_nxt = POS_NONE;
          ret_cnt_nxt  = CNT_ZERO;
          if (req_words == CNT_ZERO) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (((issue_cnt + CNT_ONE) == words) || thresh_hit) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        // issue_cnt holds the number of reads actually issued.
        if (ret_cnt_nxt == issue_cnt) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE: begin
        if (res_rdy) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = FLUSH;
      end
    endcase
  end

  // Request latch, read sequencing, best tracking and registered handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= {FC_W{1'b0}};
      req_rdy   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= {ADDR_WIDTH{1'b0}};
      res_vld   <= 1'b0;
      res_err   <= DW_ZERO;
      res_pos   <= DW_ZERO;
      target    <= DW_ZERO;
      words     <= CNT_ZERO;
      issue_cnt <= CNT_ZERO;
      ret_cnt   <= CNT_ZERO;
      best_err  <= ERR_MAX;
      best_pos  <= POS_NONE;
`ifdef MATCH_THRESH_EN
      thresh    <= DW_ZERO;
`endif
    end else begin
      flush_cnt <= (state == FLUSH) ? (flush_cnt + FC_ONE) : {FC_W{1'b0}};
      req_rdy   <= (state_nxt == IDLE);
      rd_en     <= (state_nxt == ISSUE);
      res_vld   <= (state_nxt == DONE);
      best_err  <= best_err_nxt;
      best_pos  <= best_pos_nxt;
      ret_cnt   <= ret_cnt_nxt;
      if (accept) begin
        target    <= req_target;
        words     <= req_words;
        rd_addr   <= req_base;
        issue_cnt <= CNT_ZERO;
`ifdef MATCH_THRESH_EN
        thresh    <= thresh_i;
`endif
      end else if (state == ISSUE) begin
        rd_addr   <= rd_addr + ADDR_ONE;
        issue_cnt <= issue_cnt + CNT_ONE;
      end
      // Capture the result on DONE entry; it then holds until accepted.
      if ((state_nxt == DONE) && (state != DONE)) begin
        res_err <= best_err_nxt;
        res_pos <= best_pos_nxt;
      end
    end
  end

  // Read-data alignment and per-lane error/position formation for the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe     <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        off_pipe[i] <= CNT_ZERO;
      end
      tree_vld_o <= 1'b0;
      tree_err_o <= {(LANES*DATA_WIDTH){1'b0}};
      tree_pos_o <= {(LANES*DATA_WIDTH){1'b0}};
    end else begin
      // The word offset travels with the read strobe so positions stay
      // aligned with the data that comes back RD_LAT cycles later.
      v_pipe[0]   <= rd_en;
      off_pipe[0] <= issue_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i]   <= v_pipe[i-1];
        off_pipe[i] <= off_pipe[i-1];
      end
      tree_vld_o <= v_pipe[RD_LAT-1];
      if (v_pipe[RD_LAT-1]) begin
        for (int j = 0; j < LANES; j++) begin
          // Modular subtraction gives the shortest signed phase distance.
          tree_err_o[j*DATA_WIDTH +: DATA_WIDTH] <= rd_data[j*DATA_WIDTH +: DATA_WIDTH] - target;
          tree_pos_o[j*DATA_WIDTH +: DATA_WIDTH] <= lane_pos(off_pipe[RD_LAT-1], j);
        end
      end
    end
  end

endmodule

// File: tb/tb_match_phase_ctrl.sv
module tb_match_phase_ctrl;

  localparam int DW       = 16;
  localparam int LANES    = 16;
  localparam int AW       = 10;
  localparam int RD_LAT   = 2;
  localparam int TREE_LAT = 2;
  localparam int NW       = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_vld = 1'b0;
  logic                  req_rdy;
  logic [DW-1:0]         req_target = '0;
  logic [AW-1:0]         req_base = '0;
  logic [AW:0]           req_words = '0;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [LANES*DW-1:0]   rd_data = '0;
  logic [LANES*DW-1:0]   tree_err_o;
  logic [LANES*DW-1:0]   tree_pos_o;
  logic                  tree_vld_o;
  logic [DW-1:0]         tree_err_i = '0;
  logic [DW-1:0]         tree_pos_i = '0;
  logic                  tree_vld_i = 1'b0;
  logic                  res_vld;
  logic                  res_rdy = 1'b0;
  logic [DW-1:0]         res_err;
  logic [DW-1:0]         res_pos;
`ifdef MATCH_THRESH_EN
  logic [DW-1:0]         thresh_i = '0;
`endif

  int checks   = 0;
  int failures = 0;
  int rd_count = 0;

  logic [LANES*DW-1:0] ram [NW];
  logic [LANES*DW-1:0] ram_q1 = '0;
  logic                t1_vld = 1'b0;
  logic [2*DW-1:0]     t1_wp = '0;

  always #5 clk = ~clk;

  match_phase_ctrl #(
    .DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .TREE_LAT(TREE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_target(req_target), .req_base(req_base), .req_words(req_words),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tree_err_o(tree_err_o), .tree_pos_o(tree_pos_o), .tree_vld_o(tree_vld_o),
    .tree_err_i(tree_err_i), .tree_pos_i(tree_pos_i), .tree_vld_i(tree_vld_i),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_err(res_err), .res_pos(res_pos)
`ifdef MATCH_THRESH_EN
    , .thresh_i(thresh_i)
`endif
  );

  // Magnitude of a signed phase error, clamped to 32767.
  function automatic int mag(input logic [DW-1:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  // Compare tree: smallest magnitude wins, lowest lane on ties.
  function automatic logic [2*DW-1:0] tree_pick(input logic [LANES*DW-1:0] e,
                                                input logic [LANES*DW-1:0] p);
    int best;
    logic [2*DW-1:0] r;
    best = 1 << 20;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      if (mag(e[j*DW +: DW]) < best) begin
        best = mag(e[j*DW +: DW]);
        r = {e[j*DW +: DW], p[j*DW +: DW]};
      end
    end
    return r;
  endfunction

  // Reference RAM with two-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    if (rd_en) ram_q1 <= ram[rd_addr];
    else ram_q1 <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rd_data <= ram_q1;
  end

  // Two-stage compare tree; never reset, so it can hand back stale winners.
  always @(posedge clk) begin
    t1_vld <= tree_vld_o;
    t1_wp  <= tree_pick(tree_err_o, tree_pos_o);
    tree_vld_i <= t1_vld;
    {tree_err_i, tree_pos_i} <= t1_wp;
  end

  // Count issued reads.
  always @(posedge clk) begin
    if (rd_en) rd_count <= rd_count + 1;
  end

  // Reference search: scan every candidate in order, keep the first strict minimum.
  task automatic ref_search(input logic [DW-1:0] tgt, input int base, input int words,
                            output logic [DW-1:0] e, output logic [DW-1:0] p);
    int best;
    int dv;
    int a;
    logic [DW-1:0] v;
    best = 32767;
    e = 16'h7FFF;
    p = 16'hFFFF;
    for (int k = 0; k < words; k++) begin
      for (int j = 0; j < LANES; j++) begin
        v  = ram[(base + k) % NW][j*DW +: DW];
        dv = (int'(v) - int'(tgt)) & 32'h0000FFFF;
        if (dv >= 32768) dv = dv - 65536;
        a = (dv < 0) ? -dv : dv;
        if (a > 32767) a = 32767;
        if (a < best) begin
          best = a;
          e = DW'(dv);
          p = DW'((k * LANES + j) & 32'h0000FFFF);
        end
      end
    end
  endtask

  task automatic set_lane(input int w, input int j, input logic [DW-1:0] v);
    ram[w % NW][j*DW +: DW] = v;
  endtask

  // Background entries at least 0x4000 away from the target.
  task automatic fill_far(input logic [DW-1:0] tgt, input int base, input int words);
    for (int k = 0; k < words; k++) begin
      for (int j = 0; j < LANES; j++) begin
        set_lane(base + k, j, tgt + 16'h4000 + DW'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < NW; w++) begin
      ram[w] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Present a request at a negedge and hold it until accepted.
  task automatic send_req(input logic [DW-1:0] tgt, input int base, input int words, output bit ok);
    int n;
    req_target = tgt;
    req_base   = AW'(base);
    req_words  = (AW+1)'(words);
    req_vld    = 1'b1;
    n = 0;
    while (!req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      checks++;
      failures++;
      $display("FAIL req_accept req_rdy=%0b required=1 after %0d cycles", req_rdy, n);
      req_vld = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_vld = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_res(output logic [DW-1:0] e, output logic [DW-1:0] p, output int lat, output bit ok);
    lat = 1;
    while (!res_vld && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    e = res_err;
    p = res_pos;
    if (!res_vld) begin
      checks++;
      failures++;
      $display("FAIL res_timeout res_vld=%0b required=1 after %0d cycles", res_vld, lat);
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
  endtask

  task automatic release_res();
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    checks++; if (req_rdy !== 1'b0) begin failures++; $display("FAIL rst_req_rdy got=%0b exp=0", req_rdy); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%0b exp=0", rd_en); end
    checks++; if (tree_vld_o !== 1'b0) begin failures++; $display("FAIL rst_tree_vld got=%0b exp=0", tree_vld_o); end
    checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL rst_res_vld got=%0b exp=0", res_vld); end
    checks++; if (res_err !== 16'h0000 || res_pos !== 16'h0000) begin
      failures++; $display("FAIL rst_res got=%h/%h exp=0000/0000", res_err, res_pos);
    end
    n = 0;
    while (!req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== RD_LAT + TREE_LAT + 1) begin
      failures++; $display("FAIL rst_flush_len got=%0d exp=%0d", n, RD_LAT + TREE_LAT + 1);
    end
  endtask

  task automatic test_exact_match();
    logic [DW-1:0] e, p, me, mp;
    int lat, r0;
    bit ok;
    fill_far(16'h1000, 0, 4);
    set_lane(2, 5, 16'h1000);
    ref_search(16'h1000, 0, 4, me, mp);
    r0 = rd_count;
    send_req(16'h1000, 0, 4, ok);
    if (ok) begin
      wait_res(e, p, lat, ok);
      if (ok) begin
        checks++; if (e !== 16'h0000 || p !== 16'd37) begin failures++; $display("FAIL exact_result got=%h/%0d exp=0000/37", e, p); end
        checks++; if (e !== me || p !== mp) begin failures++; $display("FAIL exact_model got=%h/%h exp=%h/%h", e, p, me, mp); end
        checks++; if (rd_count - r0 !== 4) begin failures++; $display("FAIL exact_reads got=%0d exp=4", rd_count - r0); end
        release_res();
      end
    end
  endtask

  task automatic test_zero_words();
    logic [DW-1:0] e, p;
    int lat, r0;
    bit ok;
    r0 = rd_count;
    send_req(16'h2222, 7, 0, ok);
    if (ok) begin
      wait_res(e, p, lat, ok);
      if (ok) begin
        checks++; if (e !== 16'h7FFF || p !== 16'hFFFF) begin failures++; $display("FAIL zero_result got=%h/%h exp=7fff/ffff", e, p); end
        checks++; if (lat < 1 || lat > 2) begin failures++; $display("FAIL zero_latency got=%0d exp=1..2", lat); end
        checks++; if (rd_count - r0 !== 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_count - r0); end
        release_res();
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e, p;
    int lat;
    bit ok;
    fill_far(16'h7FF0, 5, 3);
    set_lane(6, 9, 16'h8010);
    send_req(16'h7FF0, 5, 3, ok);
    if (ok) begin
      wait_res(e, p, lat, ok);
      if (ok) begin
        checks++; if (e !== 16'h0020) begin failures++; $display("FAIL wrap_err got=%h exp=0020", e); end
        checks++; if (p !== 16'd25) begin failures++; $display("FAIL wrap_pos got=%0d exp=25", p); end
        release_res();
      end
    end
  endtask

  task automatic test_tie_hold();
    logic [DW-1:0] e, p, tgt;
    int lat;
    bit ok;
    tgt = DW'($urandom);
    fill_far(tgt, 100, 5);
    set_lane(101, 4, tgt + 16'd5);
    set_lane(103, 2, tgt - 16'd5);
    send_req(tgt, 100, 5, ok);
    if (ok) begin
      wait_res(e, p, lat, ok);
      if (ok) begin
        checks++; if (e !== 16'd5 || p !== 16'd20) begin failures++; $display("FAIL tie_result got=%h/%0d exp=0005/20", e, p); end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          checks++;
          if (res_vld !== 1'b1 || res_err !== 16'd5 || res_pos !== 16'd20 || req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL hold_c%0d got vld=%0b err=%h pos=%0d rdy=%0b exp 1/0005/20/0", c, res_vld, res_err, res_pos, req_rdy);
          end
        end
        release_res();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e, p, me, mp, tgt;
    int lat, n, rdy_at;
    bit ok, seen_vld;
    fill_random();
    tgt = DW'($urandom);
    send_req(tgt, 0, 20, ok);
    if (ok) begin
      n = 0;
      while (rd_en && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen_vld = 1'b0;
      rdy_at = -1;
      for (int c = 0; c < 20; c++) begin
        if (res_vld) seen_vld = 1'b1;
        if (req_rdy && rdy_at < 0) rdy_at = c;
        @(negedge clk);
      end
      checks++; if (seen_vld !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=1 exp=0"); end
      checks++; if (rdy_at !== RD_LAT + TREE_LAT + 1) begin failures++; $display("FAIL midrst_flush got=%0d exp=%0d", rdy_at, RD_LAT + TREE_LAT + 1); end
      tgt = DW'($urandom);
      ref_search(tgt, 3, 12, me, mp);
      send_req(tgt, 3, 12, ok);
      if (ok) begin
        wait_res(e, p, lat, ok);
        if (ok) begin
          checks++; if (e !== me || p !== mp) begin failures++; $display("FAIL midrst_next got=%h/%h exp=%h/%h", e, p, me, mp); end
          release_res();
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e, p, me, mp, tgt;
    int lat, r0, base, words;
    bit ok;
    fill_random();
    for (int it = 0; it < 10; it++) begin
      tgt   = DW'($urandom);
      base  = (it == 3) ? 1020 : int'($urandom_range(0, NW - 1));
      words = (it == 5) ? 0 : int'($urandom_range(1, 40));
      ref_search(tgt, base, words, me, mp);
      r0 = rd_count;
      send_req(tgt, base, words, ok);
      if (ok) begin
        wait_res(e, p, lat, ok);
        if (ok) begin
          checks++; if (e !== me) begin failures++; $display("FAIL rand%0d_err got=%h exp=%h", it, e, me); end
          checks++; if (p !== mp) begin failures++; $display("FAIL rand%0d_pos got=%h exp=%h", it, p, mp); end
`ifndef MATCH_THRESH_EN
          checks++; if (rd_count - r0 !== words) begin failures++; $display("FAIL rand%0d_reads got=%0d exp=%0d", it, rd_count - r0, words); end
`endif
          release_res();
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e, p, me, mp, tgt;
    int lat, base, words;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      tgt   = DW'($urandom);
      base  = (it == 1) ? 1000 : int'($urandom_range(0, NW - 1));
      words = (it == 1) ? NW : 1;
      ref_search(tgt, base, words, me, mp);
      send_req(tgt, base, words, ok);
      if (ok) begin
        wait_res(e, p, lat, ok);
        if (ok) begin
          checks++; if (e !== me || p !== mp) begin failures++; $display("FAIL b2b%0d got=%h/%h exp=%h/%h", it, e, p, me, mp); end
          release_res();
        end
      end
    end
  endtask

`ifdef MATCH_THRESH_EN
  task automatic test_thresh();
    logic [DW-1:0] e, p;
    int lat, r0, reads;
    bit ok;
    fill_far(16'h3000, 0, 64);
    set_lane(0, 3, 16'h3001);
    thresh_i = 16'd2;
    r0 = rd_count;
    send_req(16'h3000, 0, 64, ok);
    thresh_i = 16'd0;
    if (ok) begin
      wait_res(e, p, lat, ok);
      if (ok) begin
        reads = rd_count - r0;
        checks++; if (e !== 16'd1 || p !== 16'd3) begin failures++; $display("FAIL thresh_result got=%h/%0d exp=0001/3", e, p); end
        checks++; if (reads >= 64 || reads < 1) begin failures++; $display("FAIL thresh_reads got=%0d exp=1..63", reads); end
        release_res();
      end
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_exact_match();
    test_zero_words();
    test_wrap();
    test_tie_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef MATCH_THRESH_EN
    test_thresh();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
